// File: rtl/tile_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : tile_frame_ctrl_if
// Purpose  : Key/vsync inputs and tile-vector outputs of tile_frame_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface tile_frame_ctrl_if #(
  parameter int NUM_TILES = 12
);
  logic                 vsync;
  logic                 enable;
  logic [NUM_TILES-1:0] keys_in;
  logic [NUM_TILES-1:0] tiles_out;
  logic                 frame_tick;
  logic                 busy;
  logic                 frame_drop;

  modport master (
    output vsync,
    output enable,
    output keys_in,
    input  tiles_out,
    input  frame_tick,
    input  busy,
    input  frame_drop
  );

  modport slave (
    input  vsync,
    input  enable,
    input  keys_in,
    output tiles_out,
    output frame_tick,
    output busy,
    output frame_drop
  );
endinterface
`default_nettype wire

// File: rtl/tile_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tile_frame_ctrl
// Purpose  : Once-per-frame key debounce / highlight hold, committing a
//            tear-free active-low tile vector to the VGA renderer.
// Revision : 1.0 - initial release
// ============================================================================
module tile_frame_ctrl #(
  parameter int NUM_TILES   = 12,
  parameter int DEBOUNCE    = 3,
  parameter int HOLD_FRAMES = 8
) (
  input  logic             clk,
  input  logic             reset,
  tile_frame_ctrl_if.slave bus
);

  localparam int c_IDX_W  = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam int c_HOLD_W = ($clog2(HOLD_FRAMES + 1) > 1) ? $clog2(HOLD_FRAMES + 1) : 1;

  localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(NUM_TILES - 1);
  localparam logic [1:0]          c_DB_LAST   = 2'(DEBOUNCE - 1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD = c_HOLD_W'(HOLD_FRAMES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    CLEAR  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                 r_vs_q1;
  logic                 r_vs_q2;
  logic                 r_frame_tick;
  logic                 w_fall;
  logic [NUM_TILES-1:0] r_key_q1;
  logic [NUM_TILES-1:0] r_key_q2;

  logic [c_IDX_W-1:0]   r_idx;
  logic [NUM_TILES-1:0] r_db_state;
  logic [NUM_TILES-1:0] r_lit_shadow;
  logic [NUM_TILES-1:0] r_tiles;
  logic [1:0]           r_db_cnt   [NUM_TILES];
  logic [c_HOLD_W-1:0]  r_hold_cnt [NUM_TILES];

  logic                 w_scan_we;
  logic                 w_clear;
  logic                 w_commit;

  logic                 w_sample;
  logic                 w_db_old;
  logic                 w_db_nxt;
  logic                 w_lit_nxt;
  logic [1:0]           w_cnt_old;
  logic [1:0]           w_cnt_nxt;
  logic [c_HOLD_W-1:0]  w_hold_old;
  logic [c_HOLD_W-1:0]  w_hold_nxt;

  // Input synchronizers; vsync flops idle high so reset release is not a fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vs_q1      <= 1'b1;
      r_vs_q2      <= 1'b1;
      r_key_q1     <= '0;
      r_key_q2     <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_vs_q1      <= bus.vsync;
      r_vs_q2      <= r_vs_q1;
      r_key_q1     <= bus.keys_in;
      r_key_q2     <= r_key_q1;
      r_frame_tick <= w_fall;
    end
  end

  assign w_fall = r_vs_q2 & ~r_vs_q1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_scan_we   = 1'b0;
    w_clear     = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_frame_tick) begin
          w_state_nxt = bus.enable ? SCAN : CLEAR;
        end
      end
      SCAN: begin
        w_scan_we = 1'b1;
        if (r_idx == c_IDX_LAST) begin
          w_state_nxt = COMMIT;
        end
      end
      CLEAR: begin
        w_clear     = 1'b1;
        w_state_nxt = COMMIT;
      end
      COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Single shared per-tile update, applied to the tile selected by r_idx.
  always_comb begin
    w_sample   = r_key_q2[r_idx];
    w_db_old   = r_db_state[r_idx];
    w_cnt_old  = r_db_cnt[r_idx];
    w_hold_old = r_hold_cnt[r_idx];
    w_db_nxt   = w_db_old;
    w_cnt_nxt  = 2'd0;
    if (w_sample != w_db_old) begin
      if (w_cnt_old == c_DB_LAST) begin
        w_db_nxt = w_sample;
      end else begin
        w_cnt_nxt = w_cnt_old + 2'd1;
      end
    end
    // The hold term uses the pre-update count so the release frame stays lit.
    w_lit_nxt = w_db_nxt | (w_hold_old != '0);
    if (w_db_nxt) begin
      w_hold_nxt = c_HOLD_LOAD;
    end else if (w_hold_old != '0) begin
      w_hold_nxt = w_hold_old - c_HOLD_W'(1);
    end else begin
      w_hold_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx        <= '0;
      r_db_state   <= '0;
      r_lit_shadow <= '0;
      r_tiles      <= '1;
      for (int i = 0; i < NUM_TILES; i++) begin
        r_db_cnt[i]   <= '0;
        r_hold_cnt[i] <= '0;
      end
    end else begin
      r_idx <= (w_scan_we && (r_idx != c_IDX_LAST)) ? r_idx + c_IDX_W'(1) : '0;
      if (w_clear) begin
        r_db_state   <= '0;
        r_lit_shadow <= '0;
        for (int i = 0; i < NUM_TILES; i++) begin
          r_db_cnt[i]   <= '0;
          r_hold_cnt[i] <= '0;
        end
      end else if (w_scan_we) begin
        r_db_state[r_idx]   <= w_db_nxt;
        r_db_cnt[r_idx]     <= w_cnt_nxt;
        r_hold_cnt[r_idx]   <= w_hold_nxt;
        r_lit_shadow[r_idx] <= w_lit_nxt;
      end
      if (w_commit) begin
        r_tiles <= ~r_lit_shadow;
      end
    end
  end

  assign bus.tiles_out  = r_tiles;
  assign bus.frame_tick = r_frame_tick;
  assign bus.busy       = (r_state != IDLE);
  assign bus.frame_drop = r_frame_tick & (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tile_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_frame_ctrl
// Purpose  : Directed frames against a per-frame behavioural model of tile_frame_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tile_frame_ctrl;

  localparam int NT   = 12;
  localparam int DEB  = 3;
  localparam int HOLD = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  tile_frame_ctrl_if #(.NUM_TILES(NT)) bus ();

  tile_frame_ctrl #(
    .NUM_TILES  (NT),
    .DEBOUNCE   (DEB),
    .HOLD_FRAMES(HOLD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  // Frame-level model: debounced level, pending count and hold per tile.
  int            m_db   [NT];
  int            m_cnt  [NT];
  int            m_hold [NT];
  logic [NT-1:0] exp_tiles;
  logic [NT-1:0] pend_val;
  int            pend_at;
  int            busy_lo;
  int            busy_hi;
  int            last_e;
  int            ticks [$];
  int            drops [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NT; i++) begin
      m_db[i]   = 0;
      m_cnt[i]  = 0;
      m_hold[i] = 0;
    end
    exp_tiles = '1;
    pend_val  = '1;
    pend_at   = -1;
    busy_lo   = -1;
    busy_hi   = -1;
    ticks.delete();
    drops.delete();
  endtask

  task automatic model_scan(input logic [NT-1:0] k, output logic [NT-1:0] v);
    for (int i = 0; i < NT; i++) begin
      int s;
      int old_hold;
      s        = k[i] ? 1 : 0;
      old_hold = m_hold[i];
      if (s == m_db[i]) begin
        m_cnt[i] = 0;
      end else if (m_cnt[i] == DEB - 1) begin
        m_db[i]  = s;
        m_cnt[i] = 0;
      end else begin
        m_cnt[i] = m_cnt[i] + 1;
      end
      v[i]      = !((m_db[i] == 1) || (old_hold != 0));
      m_hold[i] = (m_db[i] == 1) ? HOLD : ((m_hold[i] > 0) ? m_hold[i] - 1 : 0);
    end
  endtask

  // Called at the negedge where vsync drops: the next posedge is E0.
  task automatic fall_model();
    int e;
    int t;
    logic [NT-1:0] v;
    e      = cyc + 1;
    t      = e + 1;
    last_e = e;
    ticks.push_back(t);
    if (t >= busy_lo && t <= busy_hi) begin
      drops.push_back(t);
    end else begin
      busy_lo = e + 2;
      if (bus.enable) begin
        model_scan(bus.keys_in, v);
        busy_hi  = e + NT + 2;
        pend_at  = e + NT + 3;
        pend_val = v;
      end else begin
        for (int i = 0; i < NT; i++) begin
          m_db[i]   = 0;
          m_cnt[i]  = 0;
          m_hold[i] = 0;
        end
        busy_hi  = e + 3;
        pend_at  = e + 4;
        pend_val = '1;
      end
    end
  endtask

  task automatic start_frame(input logic [NT-1:0] k, input logic en);
    @(negedge clk);
    bus.keys_in = k;
    bus.enable  = en;
    fall_model();
    bus.vsync = 1'b0;
    repeat (2) @(negedge clk);
    bus.vsync = 1'b1;
  endtask

  task automatic wait_commit();
    while (cyc < pend_at) @(negedge clk);
  endtask

  task automatic frame(input logic [NT-1:0] k, input logic en);
    start_frame(k, en);
    wait_commit();
    repeat (3) @(negedge clk);
  endtask

  always @(posedge clk) begin
    bit exp_tick;
    bit exp_drop;
    cyc = cyc + 1;
    #1;
    if (chk_on) begin
      exp_tick = 1'b0;
      exp_drop = 1'b0;
      foreach (ticks[j]) if (ticks[j] == cyc) exp_tick = 1'b1;
      foreach (drops[j]) if (drops[j] == cyc) exp_drop = 1'b1;
      if (cyc == pend_at) exp_tiles = pend_val;
      check("tiles_out", 32'(bus.tiles_out), 32'(exp_tiles));
      check("busy", 32'(bus.busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
      check("frame_tick", 32'(bus.frame_tick), 32'(exp_tick));
      check("frame_drop", 32'(bus.frame_drop), 32'(exp_drop));
    end
  end

  initial begin
    bus.vsync   = 1'b1;
    bus.enable  = 1'b1;
    bus.keys_in = '0;
    model_reset();
    #1 reset = 1'b1;
    #2;
    check("rst_tiles", 32'(bus.tiles_out), 32'hFFF);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_tick", 32'(bus.frame_tick), 32'd0);
    check("rst_drop", 32'(bus.frame_drop), 32'd0);
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    chk_on = 1'b1;

    repeat (10000) @(negedge clk);
    check("idle_tiles", 32'(bus.tiles_out), 32'hFFF);

    // Steady press on tile 1: lights on the third frame, exactly E0+15.
    frame(12'h002, 1'b1);
    check("press_f1", 32'(bus.tiles_out), 32'hFFF);
    frame(12'h002, 1'b1);
    check("press_f2", 32'(bus.tiles_out), 32'hFFF);
    start_frame(12'h002, 1'b1);
    while (cyc < last_e + 14) @(negedge clk);
    check("press_pre_commit", 32'(bus.tiles_out), 32'hFFF);
    @(negedge clk);
    check("press_commit", 32'(bus.tiles_out), 32'hFFD);
    repeat (3) @(negedge clk);

    // Release: two debounce frames plus eight hold frames stay lit.
    for (int f = 1; f <= 11; f++) begin
      frame(12'h000, 1'b1);
      check("release_hold", 32'(bus.tiles_out), (f <= 10) ? 32'hFFD : 32'hFFF);
    end

    // Two-frame glitch on tile 7 is rejected; three frames are accepted.
    frame(12'h080, 1'b1);
    check("glitch_f1", 32'(bus.tiles_out), 32'hFFF);
    frame(12'h080, 1'b1);
    check("glitch_f2", 32'(bus.tiles_out), 32'hFFF);
    frame(12'h000, 1'b1);
    check("glitch_low", 32'(bus.tiles_out), 32'hFFF);
    frame(12'h080, 1'b1);
    frame(12'h080, 1'b1);
    check("press7_f2", 32'(bus.tiles_out), 32'hFFF);
    frame(12'h080, 1'b1);
    check("press7_f3", 32'(bus.tiles_out), 32'hF7F);

    // Tile 1 lit, then a disabled frame takes the CLEAR path.
    frame(12'h002, 1'b1);
    frame(12'h002, 1'b1);
    frame(12'h002, 1'b1);
    check("tile1_lit", 32'(bus.tiles_out), 32'hF7D);
    start_frame(12'h002, 1'b0);
    while (cyc < last_e + 3) @(negedge clk);
    check("clear_pre", 32'(bus.tiles_out), 32'hF7D);
    @(negedge clk);
    check("clear_commit", 32'(bus.tiles_out), 32'hFFF);
    repeat (3) @(negedge clk);
    frame(12'h002, 1'b1);
    check("reen_f1", 32'(bus.tiles_out), 32'hFFF);
    frame(12'h002, 1'b1);
    check("reen_f2", 32'(bus.tiles_out), 32'hFFF);
    frame(12'h002, 1'b1);
    check("reen_f3", 32'(bus.tiles_out), 32'hFFD);

    // A second vsync fall during the scan is dropped.
    start_frame(12'h002, 1'b1);
    while (cyc < last_e + 5) @(negedge clk);
    start_frame(12'h002, 1'b1);
    check("drop_pulse", 32'(bus.frame_drop), 32'd1);
    check("drop_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("drop_once", 32'(bus.frame_drop), 32'd0);
    wait_commit();
    repeat (20) @(negedge clk);
    check("drop_tiles", 32'(bus.tiles_out), 32'hFFD);

    // Reset while scanning tile 5 blanks at once.
    start_frame(12'h002, 1'b1);
    while (cyc < last_e + 7) @(negedge clk);
    check("scan_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_mid_tiles", 32'(bus.tiles_out), 32'hFFF);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Enable dropped mid-scan does not alter the frame already started.
    frame(12'h002, 1'b1);
    check("post_rst_f1", 32'(bus.tiles_out), 32'hFFF);
    frame(12'h002, 1'b1);
    check("post_rst_f2", 32'(bus.tiles_out), 32'hFFF);
    start_frame(12'h002, 1'b1);
    while (cyc < last_e + 5) @(negedge clk);
    bus.enable = 1'b0;
    wait_commit();
    check("late_disable", 32'(bus.tiles_out), 32'hFFD);
    bus.enable = 1'b1;
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad = bad + 1;
    $display("FAIL watchdog: run did not complete by cycle %0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tile_frame_ctrl.md
Name: tile_frame_ctrl

Overview:
- Frame-synchronous tile-state controller that drives the 12-bit `tiles` vector consumed by the VGA top. It turns the visible highlight for each tile on and off.
- Samples raw key inputs once per frame at the vsync falling edge.
- Runs per-tile debounce and highlight-hold counters, then commits one new tile vector per frame so the display never tears mid-frame.
- Sits in the pixel-clock domain (`clk_out`) between the key-input logic and the VGA renderer.

Parameters:
- NUM_TILES, 12, number of tiles/keys.
- DEBOUNCE, 3, consecutive differing frame samples needed to change a tile's debounced state (range 1..3).
- HOLD_FRAMES, 8, frames a tile stays lit after release (0 = no extension).

Ports:
- clk  in  1  pixel clock (`clk_out` of the frequency divider).
- reset  in  1  asynchronous, active-high reset.
- vsync  in  1  active-low vsync from the VGA controller.
- enable  in  1  1 = normal operation; 0 = blank all tiles and clear state.
- keys_in  in  NUM_TILES  raw key levels, 1 = pressed; asynchronous to clk.
- tiles_out  out  NUM_TILES  to VGA `tiles`; active-low, 0 = tile highlighted.
- frame_tick  out  1  one-cycle pulse per detected vsync falling edge.
- busy  out  1  1 while state != IDLE.
- frame_drop  out  1  one-cycle pulse when a vsync edge arrives while busy.

Behaviour:
- Reset values (asynchronous, all state):
  - tiles_out = all ones; frame_tick = 0; busy = 0; frame_drop = 0.
  - State = IDLE; scan index = 0.
  - All db_state, db_cnt and hold_cnt = 0; synchronizer flops = 0; vsync flops = 1.
- Synchronizers: keys_in passes through a 2-flop synchronizer. vsync goes into vs_q1 and then vs_q2.
- Edge detect:
  - fall = vs_q2 & ~vs_q1.
  - frame_tick is a register loaded with fall.
- FSM states: IDLE, SCAN, CLEAR, COMMIT.
  - IDLE:
    - frame_tick & enable -> SCAN, idx = 0.
    - frame_tick & ~enable -> CLEAR.
  - SCAN: processes tile idx each cycle. idx increments; after idx = NUM_TILES-1 -> COMMIT.
  - CLEAR: one cycle. Zeroes all db_state, db_cnt, hold_cnt and lit_shadow -> COMMIT.
  - COMMIT: one cycle. tiles_out <= ~lit_shadow -> IDLE.
- Per-tile update in SCAN, using sample s = synchronized key[idx]:
  - If s == db_state: db_cnt = 0.
  - Else if db_cnt == DEBOUNCE-1: db_state = s, db_cnt = 0.
  - Else: db_cnt = db_cnt + 1.
  - lit_shadow[idx] = new db_state | (old hold_cnt != 0).
  - If new db_state = 1: hold_cnt = HOLD_FRAMES. Otherwise hold_cnt decrements, saturating at 0.
  - Counter widths: db_cnt is 2 bits; hold_cnt is clog2(HOLD_FRAMES+1) bits, minimum 1.
- Latency:
  - Let E0 be the first rising clk edge that samples vsync = 0 after it was 1.
  - frame_tick is high for the cycle after E1.
  - tiles_out changes at edge E0 + NUM_TILES + 3 (SCAN path) or E0 + 4 (CLEAR path).
- tiles_out changes only in COMMIT; it is stable at all other times.
- A falling edge while busy is ignored (no rescan) and frame_drop pulses for that cycle. frame_tick still pulses.
- enable is sampled only in IDLE on frame_tick. Changes mid-scan take effect next frame.
- Key glitches shorter than DEBOUNCE frames never change db_state.
- Reset asserted mid-SCAN/COMMIT: immediate return to reset values. No partial commit is visible.
- vsync held low or high indefinitely: no frame_tick and no updates; tiles_out holds its value.

Test Plan:
- Reset -> tiles_out = 12'hFFF, busy = 0, frame_tick = 0, frame_drop = 0. With no vsync edges tiles_out stays 12'hFFF for 10000 cycles.
- keys_in = 12'h002 steady, three vsync falling edges -> tiles_out = 12'hFFD exactly 15 clk edges after E0 of the 3rd frame. It is 12'hFFF after frames 1 and 2.
- From the lit state above, keys_in = 0 -> tiles_out stays 12'hFFD for 8 frames after release is debounced. It is 12'hFFF at the 9th commit.
- keys_in bit 7 high for 2 frames, then low -> tiles_out bit 7 never 0. A third consecutive high frame -> bit 7 = 0 on that frame's commit.
- Tile 1 lit, enable = 0 at the next vsync edge -> CLEAR path, tiles_out = 12'hFFF at E0+4. Re-enable with key still held -> relights only after 3 more frames.
- Assert reset during SCAN idx 5 -> tiles_out = 12'hFFF immediately, busy = 0. A second vsync fall injected 6 cycles after frame_tick -> frame_drop = 1 for one cycle, no extra commit.
